alu_arbiter: RTL

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 125 ++++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared external ALU: arbitrates, captures the
// winning operation, runs it through the ALU and returns a registered response.
module alu_arbiter #(
    parameter int unsigned OP_MAX = 19
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req0_valid,
    input  logic [31:0] req0_in1,
    input  logic [31:0] req0_in2,
    input  logic [4:0]  req0_op,
    input  logic        req1_valid,
    input  logic [31:0] req1_in1,
    input  logic [31:0] req1_in2,
    input  logic [4:0]  req1_op,
    output logic        req0_ready,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic        rsp1_valid,
    input  logic        rsp0_ready,
    input  logic        rsp1_ready,
    output logic [31:0] rsp_out,
    output logic        rsp_zero,
    output logic        rsp_err,
    output logic [31:0] alu_in1,
    output logic [31:0] alu_in2,
    output logic [4:0]  alu_op,
    input  logic [31:0] alu_out,
    input  logic        alu_zero,
    output logic        busy
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    state_t      r_state;
    logic        r_prio;
    logic        r_owner;
    logic [31:0] r_in1;
    logic [31:0] r_in2;
    logic [4:0]  r_op;
    logic        r_rsp0_valid;
    logic        r_rsp1_valid;
    logic        r_busy;
    logic [31:0] r_rsp_out;
    logic        r_rsp_zero;
    logic        r_rsp_err;

    logic        w_idle;
    logic        w_grant0;
    logic        w_grant1;
    logic        w_rsp_done;
    logic        w_illegal;

    // Readies are gated by rst so nothing looks accepted while reset is held.
    assign w_idle     = (r_state == IDLE) && !rst;
    assign w_grant0   = w_idle && req0_valid && (!req1_valid || !r_prio);
    assign w_grant1   = w_idle && req1_valid && (!req0_valid ||  r_prio);
    assign w_rsp_done = (r_state == RESP) && (r_owner ? rsp1_ready : rsp0_ready);
    assign w_illegal  = (r_op == 5'd0) || ({27'd0, r_op} > OP_MAX);

    // Operand registers are cleared on completion so the ALU sees 0 whenever idle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= IDLE;
            r_prio       <= 1'b0;
            r_owner      <= 1'b0;
            r_in1        <= '0;
            r_in2        <= '0;
            r_op         <= '0;
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_rsp_out    <= '0;
            r_rsp_zero   <= 1'b0;
            r_rsp_err    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant0 || w_grant1) begin
                        r_in1   <= w_grant1 ? req1_in1 : req0_in1;
                        r_in2   <= w_grant1 ? req1_in2 : req0_in2;
                        r_op    <= w_grant1 ? req1_op  : req0_op;
                        r_owner <= w_grant1;
                        r_busy  <= 1'b1;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    r_rsp_out    <= alu_out;
                    r_rsp_zero   <= alu_zero;
                    r_rsp_err    <= w_illegal;
                    r_rsp0_valid <= !r_owner;
                    r_rsp1_valid <= r_owner;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (w_rsp_done) begin
                        r_prio       <= !r_owner;
                        r_rsp0_valid <= 1'b0;
                        r_rsp1_valid <= 1'b0;
                        r_busy       <= 1'b0;
                        r_in1        <= '0;
                        r_in2        <= '0;
                        r_op         <= '0;
                        r_state      <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign req0_ready = w_grant0;
    assign req1_ready = w_grant1;
    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp_out    = r_rsp_out;
    assign rsp_zero   = r_rsp_zero;
    assign rsp_err    = r_rsp_err;
    assign alu_in1    = r_in1;
    assign alu_in2    = r_in2;
    assign alu_op     = r_op;
    assign busy       = r_busy;

endmodule
